// File: rtl/core_pkg.sv
// ============================================================================
// Module : core_pkg
// Brief  : Shared core defaults: datapath width, register count, PC alias and
//          CPSR flag bit positions.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package core_pkg;

  localparam int CORE_DATA_W = 32;
  localparam int CORE_NREGS  = 16;
  localparam int CORE_ADDR_W = $clog2(CORE_NREGS);
  localparam int CORE_PC_IDX = 15;

  localparam int CPSR_N_BIT = 31;
  localparam int CPSR_Z_BIT = 30;
  localparam int CPSR_C_BIT = 29;
  localparam int CPSR_V_BIT = 28;

endpackage

`default_nettype wire

// File: rtl/regbank_rdport.sv
// ============================================================================
// Module : regbank_rdport
// Brief  : One register-bank read port with pending request, stall check
//          against the busy scoreboard and writeback bypass.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regbank_rdport
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int NREGS  = CORE_NREGS,
  parameter int ADDR_W = CORE_ADDR_W,
  parameter int PC_IDX = CORE_PC_IDX
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rd_req_i,
  input  logic [ADDR_W-1:0]             rd_addr_i,
  input  logic [NREGS-1:0][DATA_W-1:0]  mem_i,
  input  logic [NREGS-1:0]              busy_i,
  input  logic                          wr_en_i,
  input  logic [ADDR_W-1:0]             wr_addr_i,
  input  logic [DATA_W-1:0]             wr_data_i,
  output logic                          rd_valid_o,
  output logic [DATA_W-1:0]             rd_data_o
);

  logic              pending_q, pending_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              w_active;
  logic [ADDR_W-1:0] w_eff_addr;
  logic              w_in_range;
  logic              w_wr_hit;
  logic              w_locked;
  logic              w_resolve;
  logic [DATA_W-1:0] w_rd_word;

  generate
    if (NREGS == (1 << ADDR_W)) begin : g_full_range
      assign w_in_range = 1'b1;
    end else begin : g_partial_range
      assign w_in_range = (32'(w_eff_addr) < NREGS);
    end
  endgenerate

  // A fresh request overrides whatever address was waiting.
  assign w_active   = rd_req_i | pending_q;
  assign w_eff_addr = rd_req_i ? rd_addr_i : addr_q;
  assign w_wr_hit   = wr_en_i && (wr_addr_i == w_eff_addr);

  // The unlocking writeback itself releases the stall; its data is bypassed.
  assign w_locked   = w_in_range && busy_i[w_eff_addr] &&
                      (w_eff_addr != ADDR_W'(PC_IDX)) && !w_wr_hit;
  assign w_resolve  = w_active && !w_locked;

  always_comb begin
    w_rd_word = '0;
    if (w_in_range) begin
      w_rd_word = w_wr_hit ? wr_data_i : mem_i[w_eff_addr];
    end
  end

  always_comb begin
    pending_d = w_active && !w_resolve;
    addr_d    = w_eff_addr;
    valid_d   = w_resolve;
    data_d    = data_q;
    if (w_resolve) begin
      data_d = w_rd_word;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      addr_q    <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      addr_q    <= addr_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  assign rd_valid_o = valid_q;
  assign rd_data_o  = data_q;

endmodule

`default_nettype wire

// File: rtl/regbank_sb.sv
// ============================================================================
// Module : regbank_sb
// Brief  : Register bank with NUM_RD scoreboarded read ports, writeback port,
//          PC alias port and masked CPSR.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module regbank_sb
  import core_pkg::*;
#(
  parameter int DATA_W = CORE_DATA_W,
  parameter int NREGS  = CORE_NREGS,
  parameter int NUM_RD = 2,
  parameter int PC_IDX = CORE_PC_IDX,
  parameter int ADDR_W = $clog2(NREGS)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_RD-1:0]          rd_req,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD-1:0]          rd_valid,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       lock_en,
  input  logic [ADDR_W-1:0]          lock_addr,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       pc_we,
  input  logic [DATA_W-1:0]          pc_in,
  output logic [DATA_W-1:0]          pc_out,
  input  logic                       cpsr_we,
  input  logic [DATA_W-1:0]          cpsr_mask,
  input  logic [DATA_W-1:0]          cpsr_in,
  output logic [DATA_W-1:0]          cpsr_out,
  output logic [NREGS-1:0]           busy
);

  logic [NREGS-1:0][DATA_W-1:0] mem_q, mem_d;
  logic [NREGS-1:0]             busy_q, busy_d;
  logic [DATA_W-1:0]            cpsr_q, cpsr_d;

  logic w_wr_ok;
  logic w_lock_ok;

  generate
    if (NREGS == (1 << ADDR_W)) begin : g_full_range
      assign w_wr_ok   = 1'b1;
      assign w_lock_ok = 1'b1;
    end else begin : g_partial_range
      assign w_wr_ok   = (32'(wr_addr) < NREGS);
      assign w_lock_ok = (32'(lock_addr) < NREGS);
    end
  endgenerate

  // Writeback is applied after the PC update so a branch overrides pc_in.
  always_comb begin
    mem_d = mem_q;
    if (pc_we) begin
      mem_d[PC_IDX] = pc_in;
    end
    if (wr_en && w_wr_ok) begin
      mem_d[wr_addr] = wr_data;
    end
  end

  // Lock after unlock: a new producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    if (wr_en && w_wr_ok) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (lock_en && w_lock_ok) begin
      busy_d[lock_addr] = 1'b1;
    end
  end

  always_comb begin
    cpsr_d = cpsr_q;
    if (cpsr_we) begin
      cpsr_d = (cpsr_q & ~cpsr_mask) | (cpsr_in & cpsr_mask);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q  <= '0;
      busy_q <= '0;
      cpsr_q <= '0;
    end else begin
      mem_q  <= mem_d;
      busy_q <= busy_d;
      cpsr_q <= cpsr_d;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rdport
      regbank_rdport #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W),
        .PC_IDX (PC_IDX)
      ) u_rdport (
        .clk        (clk),
        .rst        (rst),
        .rd_req_i   (rd_req[gi]),
        .rd_addr_i  (rd_addr[gi*ADDR_W +: ADDR_W]),
        .mem_i      (mem_q),
        .busy_i     (busy_q),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .rd_valid_o (rd_valid[gi]),
        .rd_data_o  (rd_data[gi*DATA_W +: DATA_W])
      );
    end
  endgenerate

  assign pc_out   = mem_q[PC_IDX];
  assign cpsr_out = cpsr_q;
  assign busy     = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_regbank_sb.sv
// ============================================================================
// Module : tb_regbank_sb
// Brief  : Directed self-checking bench for regbank_sb with per-port
//          expected-read queues.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_regbank_sb;

  localparam int DW = 32;
  localparam int NR = 16;
  localparam int NP = 2;
  localparam int AW = 4;

  logic              clk;
  logic              rst;
  logic [NP-1:0]     rd_req;
  logic [NP*AW-1:0]  rd_addr;
  logic [NP-1:0]     rd_valid;
  logic [NP*DW-1:0]  rd_data;
  logic              lock_en;
  logic [AW-1:0]     lock_addr;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              pc_we;
  logic [DW-1:0]     pc_in;
  logic [DW-1:0]     pc_out;
  logic              cpsr_we;
  logic [DW-1:0]     cpsr_mask;
  logic [DW-1:0]     cpsr_in;
  logic [DW-1:0]     cpsr_out;
  logic [NR-1:0]     busy;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q0[$];
  logic [DW-1:0] exp_q1[$];

  regbank_sb #(
    .DATA_W (DW),
    .NREGS  (NR),
    .NUM_RD (NP),
    .PC_IDX (15)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rd_req    (rd_req),
    .rd_addr   (rd_addr),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .lock_en   (lock_en),
    .lock_addr (lock_addr),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .pc_we     (pc_we),
    .pc_in     (pc_in),
    .pc_out    (pc_out),
    .cpsr_we   (cpsr_we),
    .cpsr_mask (cpsr_mask),
    .cpsr_in   (cpsr_in),
    .cpsr_out  (cpsr_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rd_req  = '0;
    lock_en = 1'b0;
    wr_en   = 1'b0;
    pc_we   = 1'b0;
    cpsr_we = 1'b0;
  endtask

  // Every valid pulse must match the oldest outstanding expectation of its port.
  always @(negedge clk) begin
    if (!rst) begin
      if (rd_valid[0]) begin
        if (exp_q0.size() == 0) chk("p0_unexpected_valid", 32'd1, 32'd0);
        else chk("p0_data", rd_data[DW-1:0], exp_q0.pop_front());
      end
      if (rd_valid[1]) begin
        if (exp_q1.size() == 0) chk("p1_unexpected_valid", 32'd1, 32'd0);
        else chk("p1_data", rd_data[2*DW-1:DW], exp_q1.pop_front());
      end
    end
  end

  initial begin
    rst       = 1'b1;
    rd_req    = '0;
    rd_addr   = '0;
    lock_en   = 1'b0;
    lock_addr = '0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    pc_we     = 1'b0;
    pc_in     = '0;
    cpsr_we   = 1'b0;
    cpsr_mask = '0;
    cpsr_in   = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_cpsr", cpsr_out, 32'd0);
    chk("rst_valid", 32'(rd_valid), 32'd0);
    rst = 1'b0;

    // Plain write then read
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 32'hDEADBEEF;
    tick(); idle();
    rd_req[0] = 1'b1; rd_addr[3:0] = 4'd3; exp_q0.push_back(32'hDEADBEEF);
    tick(); idle();
    chk("p0_latency1", 32'(rd_valid[0]), 32'd1);

    // Stall on a locked register until writeback
    lock_en = 1'b1; lock_addr = 4'd5;
    tick(); idle();
    chk("busy5_set", 32'(busy[5]), 32'd1);
    rd_req[1] = 1'b1; rd_addr[7:4] = 4'd5;
    tick(); idle();
    for (int k = 0; k < 4; k++) begin
      chk("p1_stalled", 32'(rd_valid[1]), 32'd0);
      tick();
    end
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 32'h55; exp_q1.push_back(32'h55);
    tick(); idle();
    chk("p1_unstall_valid", 32'(rd_valid[1]), 32'd1);
    chk("busy5_clear", 32'(busy[5]), 32'd0);

    // Same-cycle write bypass
    rd_req[0] = 1'b1; rd_addr[3:0] = 4'd7;
    wr_en = 1'b1; wr_addr = 4'd7; wr_data = 32'h77; exp_q0.push_back(32'h77);
    tick(); idle();
    chk("bypass_valid", 32'(rd_valid[0]), 32'd1);

    // PC write priority
    pc_we = 1'b1; pc_in = 32'h100;
    wr_en = 1'b1; wr_addr = 4'd15; wr_data = 32'h200;
    tick(); idle();
    chk("pc_wb_wins", pc_out, 32'h200);
    pc_we = 1'b1; pc_in = 32'h104;
    tick(); idle();
    chk("pc_alone", pc_out, 32'h104);

    // PC reads ignore a lock on the PC register
    lock_en = 1'b1; lock_addr = 4'd15;
    tick(); idle();
    rd_req[1] = 1'b1; rd_addr[7:4] = 4'd15; exp_q1.push_back(32'h104);
    tick(); idle();
    chk("pc_read_nostall", 32'(rd_valid[1]), 32'd1);

    // Masked CPSR updates
    cpsr_we = 1'b1; cpsr_mask = 32'hF0000000; cpsr_in = 32'hA0000FFF;
    tick(); idle();
    chk("cpsr_flags", cpsr_out, 32'hA0000000);
    cpsr_we = 1'b1; cpsr_mask = 32'h0000000F; cpsr_in = 32'hFFFFFFF5;
    tick(); idle();
    chk("cpsr_low", cpsr_out, 32'hA0000005);

    // Both ports in the same cycle
    rd_req = 2'b11; rd_addr = {4'd7, 4'd3};
    exp_q0.push_back(32'hDEADBEEF); exp_q1.push_back(32'h77);
    tick(); idle();
    chk("dual_valid", 32'(rd_valid), 32'd3);

    // New request replaces a stalled address
    lock_en = 1'b1; lock_addr = 4'd2;
    tick(); idle();
    rd_req[0] = 1'b1; rd_addr[3:0] = 4'd2;
    tick(); idle();
    chk("p0_stall_r2", 32'(rd_valid[0]), 32'd0);
    rd_req[0] = 1'b1; rd_addr[3:0] = 4'd3; exp_q0.push_back(32'hDEADBEEF);
    tick(); idle();
    chk("p0_replaced", 32'(rd_valid[0]), 32'd1);
    tick();
    chk("p0_no_extra", 32'(rd_valid[0]), 32'd0);

    // Lock and writeback colliding: register stays busy
    lock_en = 1'b1; lock_addr = 4'd6;
    wr_en = 1'b1; wr_addr = 4'd6; wr_data = 32'h66;
    tick(); idle();
    chk("busy6_lock_wins", 32'(busy[6]), 32'd1);

    // Reset with a read stalled on R2
    rd_req[1] = 1'b1; rd_addr[7:4] = 4'd2;
    tick(); idle();
    chk("p1_stall_prerst", 32'(rd_valid[1]), 32'd0);
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = 4'd9; wr_data = 32'h99;
    tick(); idle();
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_pc", pc_out, 32'd0);
    chk("mid_rst_cpsr", cpsr_out, 32'd0);
    chk("mid_rst_valid", 32'(rd_valid), 32'd0);
    chk("mid_rst_data0", rd_data[DW-1:0], 32'd0);
    chk("mid_rst_data1", rd_data[2*DW-1:DW], 32'd0);
    wr_en = 1'b1; wr_addr = 4'd2; wr_data = 32'h22;
    tick(); idle();
    for (int k = 0; k < 3; k++) begin
      chk("post_rst_no_valid", 32'(rd_valid), 32'd0);
      tick();
    end
    rd_req[0] = 1'b1; rd_addr[3:0] = 4'd3; exp_q0.push_back(32'd0);
    tick(); idle();
    chk("post_rst_r3_valid", 32'(rd_valid[0]), 32'd1);
    tick();
    tick();

    chk("drain_q0", 32'(exp_q0.size()), 32'd0);
    chk("drain_q1", 32'(exp_q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
